uart_tx_queue: RTL and testbench

Byte queue sitting directly upstream of the UART controller's transmit path. A host writes bytes at any rate up to one per clock; the block buffers them in a circular FIFO and hands them one at a time to the transmitter via `din`/`tx_en`, pacing on the transmitter's `tx_rdy` status. It frees the host from tracking frame timing and baud rate.

---
 rtl/uart_tx_queue.sv | 98 +++++++++
 tb/tb_uart_tx_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Circular byte FIFO feeding the UART transmitter one byte per tx_rdy handshake.
// Optional sticky overflow flag (ovf/ovf_clr) is built when UART_TXQ_OVF_EN is defined.
module uart_tx_queue #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  tx_rdy,
  output logic [7:0]            din,
  output logic                  tx_en
`ifdef UART_TXQ_OVF_EN
  ,
  output logic                  ovf,
  input  logic                  ovf_clr
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  push, pop;

  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);
  assign push  = wr_en && !full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && tx_rdy) begin
          pop       = 1'b1;
          state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: if (!tx_rdy) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_rdy)  state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Storage is never cleared; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      din    <= '0;
      tx_en  <= 1'b0;
    end else begin
      tx_en <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        din    <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TXQ_OVF_EN
  // A new overflow on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst)                ovf <= 1'b0;
    else if (wr_en && full)  ovf <= 1'b1;
    else if (ovf_clr)        ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: constant vector table, directed corner sequences and a
// randomized run against a queue-based reference model. Handles UART_TXQ_OVF_EN either way.
module tb_uart_tx_queue;

  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned DEPTH      = 16;

  logic                clk = 1'b0;
  logic                rst, wr_en, tx_rdy, ovf_clr;
  logic [7:0]          wr_data;
  logic                full, empty, tx_en;
  logic [7:0]          din;
  logic [DEPTH_LOG2:0] count;
`ifdef UART_TXQ_OVF_EN
  logic                ovf;
`endif

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .tx_rdy  (tx_rdy),
    .din     (din),
    .tx_en   (tx_en)
`ifdef UART_TXQ_OVF_EN
    ,
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: byte queue plus the handshake phase of the current frame.
  logic [7:0] q[$];
  bit         can_pop   = 1'b1;
  bit         need_fall = 1'b0;
  logic [7:0] exp_din   = 8'h00;
  bit         exp_tx_en = 1'b0;
  bit         exp_ovf   = 1'b0;

  logic [7:0] got[$];
  int         busy_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit do_pop, do_push;
    if (!rst) begin
      q.delete();
      can_pop   = 1'b1;
      need_fall = 1'b0;
      exp_din   = 8'h00;
      exp_tx_en = 1'b0;
      exp_ovf   = 1'b0;
      return;
    end
    do_pop  = can_pop && (q.size() != 0) && tx_rdy;
    do_push = wr_en && (q.size() < DEPTH);
    if (wr_en && q.size() == DEPTH) exp_ovf = 1'b1;
    else if (ovf_clr)              exp_ovf = 1'b0;
    exp_tx_en = do_pop;
    if (do_pop) exp_din = q.pop_front();
    if (do_push) q.push_back(wr_data);
    if (can_pop) begin
      if (do_pop) begin
        can_pop   = 1'b0;
        need_fall = 1'b1;
      end
    end else if (need_fall) begin
      if (!tx_rdy) need_fall = 1'b0;
    end else if (tx_rdy) begin
      can_pop = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check("m_count", 32'(count), 32'(q.size()));
    check("m_empty", 32'(empty), 32'(q.size() == 0));
    check("m_full",  32'(full),  32'(q.size() == DEPTH));
    check("m_tx_en", 32'(tx_en), 32'(exp_tx_en));
    check("m_din",   32'(din),   32'(exp_din));
`ifdef UART_TXQ_OVF_EN
    check("m_ovf",   32'(ovf),   32'(exp_ovf));
`endif
  endtask

  task automatic tick(input logic r, input logic w, input logic [7:0] d,
                      input logic rdy, input logic clr);
    rst = r; wr_en = w; wr_data = d; tx_rdy = rdy; ovf_clr = clr;
    cycle();
  endtask

  // Transmitter stand-in: drops tx_rdy for a few cycles after each tx_en pulse.
  task automatic run_xmit(input int ncyc, input bit rnd);
    for (int c = 0; c < ncyc; c++) begin
      if (rnd) begin
        rst     = ($urandom_range(0, 299) != 0);
        wr_en   = ($urandom_range(0, 2) != 0);
        wr_data = 8'($urandom);
        ovf_clr = ($urandom_range(0, 15) == 0);
      end else begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
      end
      if (busy_left > 0) begin
        tx_rdy = 1'b0;
        busy_left--;
      end else begin
        tx_rdy = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      end
      cycle();
      if (tx_en) begin
        got.push_back(din);
        busy_left = rnd ? int'($urandom_range(1, 8)) : 4;
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_rdy;
    logic [4:0] exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_tx_en;
    logic [7:0] exp_din;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'h33, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h44, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[6]  = '{1'b1, 1'b1, 8'hB6, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'hB6};

    ovf_clr = 1'b0;
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; wr_en = tbl[i].wr_en; wr_data = tbl[i].wr_data; tx_rdy = tbl[i].tx_rdy;
      cycle();
      check("tbl_count", 32'(count), 32'(tbl[i].exp_count));
      check("tbl_empty", 32'(empty), 32'(tbl[i].exp_empty));
      check("tbl_full",  32'(full),  32'(tbl[i].exp_full));
      check("tbl_tx_en", 32'(tx_en), 32'(tbl[i].exp_tx_en));
      check("tbl_din",   32'(din),   32'(tbl[i].exp_din));
    end

    // Transmitter held busy for 10 cycles: no pulse until tx_rdy returns.
    tick(1, 1, 8'hC3, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 8'h00, 0, 0);
      check("busy_hold_tx_en", 32'(tx_en), 32'd0);
    end
    tick(1, 0, 8'h00, 1, 0);
    check("busy_release_tx_en", 32'(tx_en), 32'd0);
    tick(1, 0, 8'h00, 1, 0);
    check("busy_next_tx_en", 32'(tx_en), 32'd1);
    check("busy_next_din",   32'(din),   32'hC3);

    // Burst of 16 with transmitter busy, then overflow attempts.
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) tick(1, 1, 8'(i + 1), 0, 0);
    check("burst_count", 32'(count), 32'd16);
    check("burst_full",  32'(full),  32'd1);
    tick(1, 1, 8'hFF, 0, 0);
    check("ovf_count", 32'(count), 32'd16);
`ifdef UART_TXQ_OVF_EN
    check("ovf_set", 32'(ovf), 32'd1);
    tick(1, 0, 8'h00, 0, 1);
    check("ovf_clr", 32'(ovf), 32'd0);
    tick(1, 1, 8'hFF, 0, 1);
    check("ovf_set_wins", 32'(ovf), 32'd1);
    tick(1, 0, 8'h00, 0, 1);
    check("ovf_clr2", 32'(ovf), 32'd0);
`endif

    got.delete();
    busy_left = 0;
    run_xmit(120, 1'b0);
    check("drain_len", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check("drain_order", 32'(got[i]), 32'(i + 1));
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // Push and pop on the same edge.
    tick(1, 1, 8'h11, 0, 0);
    check("pp_pre_count", 32'(count), 32'd1);
    tick(1, 1, 8'h5A, 1, 0);
    check("pp_count", 32'(count), 32'd1);
    check("pp_tx_en", 32'(tx_en), 32'd1);
    check("pp_din",   32'(din),   32'h11);
    tick(1, 0, 8'h00, 0, 0);
    tick(1, 0, 8'h00, 1, 0);
    tick(1, 0, 8'h00, 1, 0);
    check("pp_next_tx_en", 32'(tx_en), 32'd1);
    check("pp_next_din",   32'(din),   32'h5A);
    check("pp_next_count", 32'(count), 32'd0);

    // Reset while a frame is in flight with bytes queued.
    tick(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 8'(8'h20 + i), 0, 0);
    check("mid_count", 32'(count), 32'd5);
    tick(0, 0, 8'h00, 0, 0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_din",   32'(din),   32'h00);
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 8'h00, 1, 0);
      check("mid_no_tx_en", 32'(tx_en), 32'd0);
      check("mid_count0",   32'(count), 32'd0);
    end

    got.delete();
    busy_left = 0;
    run_xmit(3000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
